// File: rtl/alu_pkg.sv
// Shared definitions for the byte-serial ALU adder: slice width,
// controller state encoding and the slice-index counter width.
package alu_pkg;

  localparam int SLICE_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bits needed to count n slices; never less than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/byte_serial_adder32_cra8.sv
// CRA8: 8-bit ripple-carry adder cell, the only arithmetic in the unit.
module CRA8
  import alu_pkg::*;
(
  input  logic [SLICE_W-1:0] i_a,
  input  logic [SLICE_W-1:0] i_b,
  input  logic               i_cin,
  output logic [SLICE_W-1:0] o_s,
  output logic               o_cout
);

  logic [SLICE_W:0] w_c;

  // Ripple the carry bit by bit through full-adder cells.
  always_comb begin
    w_c    = '0;
    o_s    = '0;
    w_c[0] = i_cin;
    for (int i = 0; i < SLICE_W; i++) begin
      o_s[i]   = i_a[i] ^ i_b[i] ^ w_c[i];
      w_c[i+1] = (i_a[i] & i_b[i]) | (w_c[i] & (i_a[i] ^ i_b[i]));
    end
    o_cout = w_c[SLICE_W];
  end

endmodule

// File: rtl/byte_serial_adder32.sv
// Multi-cycle add/subtract unit: one 8-bit slice per cycle, LSB first,
// valid/ready handshakes on operands and on the registered result.
module byte_serial_adder32
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             overflow,
  output logic             zero
);

  localparam int NUM_SLICES = WIDTH / SLICE_W;
  localparam int IDX_W      = idx_width(NUM_SLICES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SLICES - 1);

  state_t           r_state;
  state_t           w_state_next;
  logic [IDX_W-1:0] r_idx;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_c;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic             r_ovf;
  logic             r_zero;
  logic             r_out_valid;

  logic [SLICE_W-1:0] w_sa;
  logic [SLICE_W-1:0] w_sb;
  logic [SLICE_W-1:0] w_ss;
  logic               w_cout;
  logic [WIDTH-1:0]   w_sum_next;
  logic               w_c_into_msb;
  logic               w_accept;
  logic               w_last;
  logic               w_release;
  int                 w_base;

  assign w_accept  = (r_state == IDLE) && in_valid;
  assign w_last    = (r_state == RUN) && (r_idx == LAST_IDX);
  assign w_release = (r_state == DONE) && out_ready;
  assign in_ready  = (r_state == IDLE) && !rst;

  assign w_base = int'(r_idx) * SLICE_W;
  assign w_sa   = r_a[w_base +: SLICE_W];
  assign w_sb   = r_b[w_base +: SLICE_W];

  CRA8 u_cra8 (
    .i_a    (w_sa),
    .i_b    (w_sb),
    .i_cin  (r_c),
    .o_s    (w_ss),
    .o_cout (w_cout)
  );

  // Result as it will look once the current slice is written; the flags
  // of the final slice are derived from this rather than from r_sum.
  always_comb begin
    w_sum_next = r_sum;
    w_sum_next[w_base +: SLICE_W] = w_ss;
    w_c_into_msb = r_a[WIDTH-1] ^ r_b[WIDTH-1] ^ w_sum_next[WIDTH-1];
  end

  // Controller state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  // Next-state decode: accept, walk the slices, hold until consumed.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_accept)  w_state_next = RUN;
      RUN:     if (w_last)    w_state_next = DONE;
      DONE:    if (w_release) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Operand capture, per-slice accumulation and final flag generation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx       <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_c         <= 1'b0;
      r_sum       <= '0;
      r_carry     <= 1'b0;
      r_ovf       <= 1'b0;
      r_zero      <= 1'b0;
      r_out_valid <= 1'b0;
    end else if (w_accept) begin
      r_a   <= a;
      r_b   <= b ^ {WIDTH{sub}};
      r_c   <= sub;
      r_idx <= '0;
    end else if (r_state == RUN) begin
      r_sum <= w_sum_next;
      r_c   <= w_cout;
      r_idx <= w_last ? '0 : r_idx + 1'b1;
      if (w_last) begin
        r_carry     <= w_cout;
        r_ovf       <= w_c_into_msb ^ w_cout;
        r_zero      <= (w_sum_next == '0);
        r_out_valid <= 1'b1;
      end
    end else if (w_release) begin
      r_out_valid <= 1'b0;
    end
  end

  assign sum       = r_sum;
  assign carry     = r_carry;
  assign overflow  = r_ovf;
  assign zero      = r_zero;
  assign out_valid = r_out_valid;

endmodule
